// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    ADJUST = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic SEL_SEC = 1'b0;
  localparam logic SEL_MIN = 1'b1;

endpackage

// File: rtl/stopwatch_if.sv
// Button/clock-level inputs and display-side outputs of the stopwatch controller.
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic sec_clk;
  logic blink_clk;
  logic btn_start;
  logic btn_clear;
  logic adj;
  logic sel;
  bcd_t min_tens;
  bcd_t min_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;
  logic running;
  logic blank_min;
  logic blank_sec;
  logic wrap;

  // master: the controller itself
  modport master (
    input  sec_clk, blink_clk, btn_start, btn_clear, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones,
    output running, blank_min, blank_sec, wrap
  );

  // slave: buttons, clock generator and display multiplexer side
  modport slave (
    output sec_clk, blink_clk, btn_start, btn_clear, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  running, blank_min, blank_sec, wrap
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps MAX -> 00; carry flags the wrapping increment.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry
);

  localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);
  localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);

  bcd_t tens_reg, tens_next;
  bcd_t ones_reg, ones_next;
  logic at_max;

  assign at_max = (tens_reg == MAX_TENS) && (ones_reg == MAX_ONES);
  assign carry  = inc & at_max;
  assign tens   = tens_reg;
  assign ones   = ones_reg;

  always_comb begin
    tens_next = tens_reg;
    ones_next = ones_reg;
    if (clr) begin
      tens_next = '0;
      ones_next = '0;
    end else if (inc) begin
      if (at_max) begin
        tens_next = '0;
        ones_next = '0;
      end else if (ones_reg == 4'd9) begin
        tens_next = tens_reg + 4'd1;
        ones_next = '0;
      end else begin
        ones_next = ones_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_reg <= '0;
      ones_reg <= '0;
    end else begin
      tens_reg <= tens_next;
      ones_reg <= ones_next;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/adjust sequencer driving a BCD MM:SS count and display blanking.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = 59,
  parameter int SEC_MAX = 59
) (
  input logic       clk,
  input logic       rst,
  stopwatch_if.master sw
);

  state_t state_reg, state_next;
  logic   sec_q, start_q, clear_q;
  logic   tick, start_rise, clear_rise;
  logic   count_run, adj_tick;
  logic   sec_inc, min_inc, sec_carry, min_carry;
  logic   running_reg, blank_sec_reg, blank_min_reg, wrap_reg;

  // Copies always track the inputs, including during reset, so a level held
  // across reset release or a state change never looks like a fresh edge.
  always_ff @(posedge clk) begin
    sec_q   <= sw.sec_clk;
    start_q <= sw.btn_start;
    clear_q <= sw.btn_clear;
  end

  assign tick       = sw.sec_clk & ~sec_q;
  assign start_rise = sw.btn_start & ~start_q;
  assign clear_rise = sw.btn_clear & ~clear_q;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (clear_rise)      state_next = IDLE;
        else if (start_rise) state_next = RUN;
        else if (sw.adj)     state_next = ADJUST;
      end
      RUN: begin
        if (clear_rise)      state_next = IDLE;
        else if (start_rise) state_next = PAUSE;
      end
      PAUSE: begin
        if (clear_rise)      state_next = IDLE;
        else if (start_rise) state_next = RUN;
        else if (sw.adj)     state_next = ADJUST;
      end
      ADJUST: begin
        if (clear_rise)      state_next = IDLE;
        else if (!sw.adj)    state_next = PAUSE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A tick in RUN is honoured even alongside start_rise; clear always wins.
  assign count_run = (state_reg == RUN) & tick & ~clear_rise;
  assign adj_tick  = (state_reg == ADJUST) & tick & ~clear_rise;
  assign sec_inc   = count_run | (adj_tick & (sw.sel == SEL_SEC));
  assign min_inc   = (count_run & sec_carry) | (adj_tick & (sw.sel == SEL_MIN));

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .clr(clear_rise), .inc(sec_inc),
    .tens(sw.sec_tens), .ones(sw.sec_ones), .carry(sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .clr(clear_rise), .inc(min_inc),
    .tens(sw.min_tens), .ones(sw.min_ones), .carry(min_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      running_reg   <= 1'b0;
      blank_sec_reg <= 1'b0;
      blank_min_reg <= 1'b0;
      wrap_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      running_reg   <= (state_next == RUN);
      blank_sec_reg <= (state_reg == ADJUST) & (sw.sel == SEL_SEC) & sw.blink_clk;
      blank_min_reg <= (state_reg == ADJUST) & (sw.sel == SEL_MIN) & sw.blink_clk;
      wrap_reg      <= count_run & sec_carry & min_carry;
    end
  end

  assign sw.running   = running_reg;
  assign sw.blank_sec = blank_sec_reg;
  assign sw.blank_min = blank_min_reg;
  assign sw.wrap      = wrap_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed checks of stopwatch_ctrl with hand-computed MM:SS expectations.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   wrap_cnt = 0;

  stopwatch_if sw ();

  stopwatch_ctrl #(.MIN_MAX(59), .SEC_MAX(59)) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (sw.wrap === 1'b1) wrap_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sw.sec_clk = 1'b1;
      step();
      sw.sec_clk = 1'b0;
      step();
    end
  endtask

  task automatic press_start();
    sw.btn_start = 1'b1;
    step();
    sw.btn_start = 1'b0;
    step();
  endtask

  task automatic press_clear();
    sw.btn_clear = 1'b1;
    step();
    sw.btn_clear = 1'b0;
    step();
  endtask

  // From IDLE or PAUSE: load mm:ss through ADJUST, end in RUN.
  task automatic preload_run(input int mm, input int ss);
    sw.adj = 1'b1;
    step();
    sw.sel = 1'b1;
    step();
    ticks(mm);
    sw.sel = 1'b0;
    step();
    ticks(ss);
    sw.adj = 1'b0;
    step();
    press_start();
  endtask

  initial begin
    rst = 1'b1;
    sw.sec_clk = 0; sw.blink_clk = 0; sw.btn_start = 0;
    sw.btn_clear = 0; sw.adj = 0; sw.sel = 0;
    step(); step(); step();
    chk("reset_digits", 32'(digits()), 32'h0000);
    chk("reset_running", 32'(sw.running), 32'd0);
    chk("reset_blank", 32'({sw.blank_min, sw.blank_sec}), 32'd0);
    chk("reset_wrap", 32'(sw.wrap), 32'd0);
    rst = 1'b0;
    step();

    // Ticks in IDLE are ignored, then 61 counted ticks give 01:01
    ticks(2);
    chk("idle_ticks", 32'(digits()), 32'h0000);
    press_start();
    chk("start_running", 32'(sw.running), 32'd1);
    wrap_cnt = 0;
    ticks(61);
    chk("run_61", 32'(digits()), 32'h0101);
    chk("run_61_nowrap", 32'(wrap_cnt), 32'd0);

    // Seconds carry into minutes
    press_clear();
    chk("clear_idle", 32'(sw.running), 32'd0);
    chk("clear_digits", 32'(digits()), 32'h0000);
    press_start();
    ticks(59);
    chk("run_0059", 32'(digits()), 32'h0059);
    ticks(1);
    chk("carry_0100", 32'(digits()), 32'h0100);

    // 59:59 -> 00:00 wrap pulse
    press_start();
    chk("pause", 32'(sw.running), 32'd0);
    sw.adj = 1'b1;
    step();
    sw.sel = 1'b0;
    ticks(59);
    sw.sel = 1'b1;
    step();
    ticks(58);
    sw.adj = 1'b0;
    sw.sel = 1'b0;
    step();
    press_start();
    chk("preload_5959", 32'(digits()), 32'h5959);
    wrap_cnt = 0;
    sw.sec_clk = 1'b1;
    step();
    chk("wrap_high", 32'(sw.wrap), 32'd1);
    chk("wrap_digits", 32'(digits()), 32'h0000);
    sw.sec_clk = 1'b0;
    step();
    chk("wrap_low", 32'(sw.wrap), 32'd0);
    chk("wrap_one_cycle", 32'(wrap_cnt), 32'd1);

    // Simultaneous tick and start in RUN
    ticks(10);
    chk("run_0010", 32'(digits()), 32'h0010);
    sw.sec_clk = 1'b1; sw.btn_start = 1'b1;
    step();
    sw.sec_clk = 1'b0; sw.btn_start = 1'b0;
    step();
    chk("tick_start_digits", 32'(digits()), 32'h0011);
    chk("tick_start_paused", 32'(sw.running), 32'd0);
    ticks(3);
    chk("pause_hold", 32'(digits()), 32'h0011);
    press_start();
    chk("resume_running", 32'(sw.running), 32'd1);
    ticks(1);
    chk("resume_count", 32'(digits()), 32'h0012);

    // ADJUST from PAUSE at 00:30
    ticks(18);
    press_start();
    chk("pause_0030", 32'(digits()), 32'h0030);
    sw.adj = 1'b1; sw.sel = 1'b0;
    step();
    ticks(35);
    chk("adj_sec_nocarry", 32'(digits()), 32'h0005);
    sw.blink_clk = 1'b1;
    step(); step();
    chk("blank_sec_on", 32'({sw.blank_min, sw.blank_sec}), 32'b01);
    sw.blink_clk = 1'b0;
    step();
    chk("blank_sec_off", 32'({sw.blank_min, sw.blank_sec}), 32'b00);
    sw.sel = 1'b1;
    step();
    ticks(3);
    chk("adj_min", 32'(digits()), 32'h0305);
    sw.blink_clk = 1'b1;
    step(); step();
    chk("blank_min_on", 32'({sw.blank_min, sw.blank_sec}), 32'b10);
    sw.adj = 1'b0;
    step(); step();
    chk("blank_pause", 32'({sw.blank_min, sw.blank_sec}), 32'b00);
    sw.blink_clk = 1'b0;
    sw.sel = 1'b0;

    // Clear and tick together at 02:17, then start held through reset
    press_clear();
    preload_run(2, 17);
    chk("run_0217", 32'(digits()), 32'h0217);
    chk("run_0217_running", 32'(sw.running), 32'd1);
    sw.sec_clk = 1'b1; sw.btn_clear = 1'b1;
    step();
    chk("clear_tick_digits", 32'(digits()), 32'h0000);
    chk("clear_tick_idle", 32'(sw.running), 32'd0);
    sw.sec_clk = 1'b0; sw.btn_clear = 1'b0;
    step();
    rst = 1'b1; sw.btn_start = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("held_start_no_run", 32'(sw.running), 32'd0);
    ticks(1);
    chk("held_start_no_count", 32'(digits()), 32'h0000);
    sw.btn_start = 1'b0;
    step();

    // Reset mid-RUN at 05:42 with ticks during and after
    preload_run(5, 42);
    chk("run_0542", 32'(digits()), 32'h0542);
    rst = 1'b1; sw.sec_clk = 1'b1;
    step();
    chk("rst_digits", 32'(digits()), 32'h0000);
    chk("rst_outputs", 32'({sw.running, sw.blank_min, sw.blank_sec, sw.wrap}), 32'd0);
    sw.sec_clk = 1'b0;
    step();
    sw.sec_clk = 1'b1;
    step();
    rst = 1'b0;
    step();
    sw.sec_clk = 1'b0;
    step();
    ticks(2);
    chk("post_rst_idle", 32'(digits()), 32'h0000);
    chk("post_rst_running", 32'(sw.running), 32'd0);
    press_start();
    ticks(1);
    chk("post_rst_count", 32'(digits()), 32'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/pause/clear/adjust controller for the stopwatch. Consumes the divided sec_clk and blink_clk outputs of the clock generator as level signals sampled on the master clock. Sequences a BCD MM:SS count and drives the display-side digit and blanking signals. Sits between the debounced button inputs, the clock generator, and the display multiplexer, which runs off display_clk.

Parameters:
MIN_MAX, 59, last minutes value before wrap to 00 (BCD-legal, 1..99)
SEC_MAX, 59, last seconds value before wrap to 00 (fixed use 59; parameter for sim speed-up)

Ports:
clk  in  1  master clock
rst  in  1  synchronous, active-high reset
sec_clk  in  1  1 Hz divided clock level; rising edge = one count tick
blink_clk  in  1  blink divided clock level; gates blanking in ADJUST
btn_start  in  1  debounced start/pause button level
btn_clear  in  1  debounced clear button level
adj  in  1  adjust-mode switch level
sel  in  1  adjust field select: 0 = seconds, 1 = minutes
min_tens  out  4  BCD minutes tens
min_ones  out  4  BCD minutes ones
sec_tens  out  4  BCD seconds tens
sec_ones  out  4  BCD seconds ones
running  out  1  1 while in RUN
blank_min  out  1  display must blank minute digits
blank_sec  out  1  display must blank second digits
wrap  out  1  one-cycle pulse on MIN_MAX:SEC_MAX -> 00:00 in RUN

Behaviour:
- Single clock domain (clk); all inputs sampled at the rising edge of clk. rst is synchronous and active-high.
- Edge detect: registered copies of sec_clk, btn_start and btn_clear.
  - tick = sec_clk & ~sec_q; start_rise and clear_rise are formed the same way.
  - During rst the copies load the current input values, so no spurious edge appears at reset release.
- Reset: state=IDLE, all digits 0, running=0, blank_*=0, wrap=0.
- States and transitions, evaluated per cycle in priority order clear_rise > start_rise > adj > tick:
  - IDLE: start_rise -> RUN; else adj=1 -> ADJUST. Ticks ignored.
  - RUN: clear_rise -> IDLE with digits zeroed; start_rise -> PAUSE; adj ignored. A tick increments the count.
  - PAUSE: clear_rise -> IDLE with digits zeroed; start_rise -> RUN; adj=1 -> ADJUST. Ticks ignored.
  - ADJUST: clear_rise -> IDLE with digits zeroed; adj=0 -> PAUSE; start_rise ignored. A tick increments only the field chosen by sel, with no carry between fields.
- Simultaneous events:
  - Tick and start_rise in RUN: the tick is applied and the state becomes PAUSE in the same cycle.
  - Tick and clear_rise: clear wins and digits become 00:00.
- Latency: digits update on the same clk edge at which the tick is detected, so they are visible one cycle after sec_clk is first sampled high.
- Arithmetic: each field is a two-digit BCD counter.
  - Ones wrap 9 -> 0 with a carry into tens.
  - Seconds wrap at SEC_MAX -> 00 and, in RUN only, carry +1 into minutes.
  - Minutes wrap at MIN_MAX -> 00.
  - wrap is registered and pulses for 1 cycle on the 59:59 -> 00:00 tick in RUN.
  - Digits never hold non-BCD values.
- running = (state==RUN), registered.
- Blanking, registered, 1-cycle lag behind blink_clk:
  - blank_sec = ADJUST & ~sel & blink_clk.
  - blank_min = ADJUST & sel & blink_clk.
  - Both are 0 in all other states.
- Mid-operation rst: returns to IDLE/00:00 on that edge regardless of inputs.
- Held buttons produce exactly one action per press; a level held across a state change is never re-triggered.

Decomposition:
- Package stopwatch_pkg holds:
  - state enum {IDLE, RUN, PAUSE, ADJUST}, 2 bits
  - bcd_t (4 bits)
  - SEL_SEC / SEL_MIN constants
- Sub-module bcd_mod_counter:
  - parameter MAX
  - ports clk, rst, clr, inc, tens, ones, carry (combinational carry = inc & at MAX)
  - instantiated once for seconds and once for minutes

Test Plan:
- Reset then start_rise, 61 ticks -> digits 01:01, running=1, wrap never asserted.
- RUN at 00:59, tick -> 01:00; preload 59:59 via ADJUST, RUN, tick -> 00:00 with wrap high exactly 1 cycle.
- RUN, start_rise and tick in the same cycle at 00:10 -> 00:11, state PAUSE; further ticks leave 00:11; start_rise -> counting resumes.
- PAUSE at 00:30, adj=1, sel=0, 35 ticks -> 00:05 with minutes unchanged. Then sel=1, 3 ticks -> 03:05. blank_sec follows blink_clk only while sel=0; blank_min follows blink_clk only while sel=1.
- RUN at 02:17, clear_rise and tick in the same cycle -> 00:00, IDLE, running=0; btn_start held high through rst -> no transition after release.
- rst asserted mid-RUN at 05:42 -> next edge shows 00:00 with all outputs 0; ticks during and after rst do not count until start_rise.
